// File: rtl/bp_gshare.sv
// IF-stage branch predictor: tagged direct-mapped BTB plus a 2-bit counter PHT.
// Define BP_GSHARE_EN for gshare indexing with a speculative GHR; otherwise bimodal.
module bp_gshare #(
    parameter int PC_W      = 32,
    parameter int PHT_IDX_W = 10,
    parameter int BTB_IDX_W = 6,
    parameter int TAG_W     = 12,
    parameter int GHR_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             if_allowin_i,
    output logic             pred_valid_o,
    output logic             pred_taken_o,
    output logic             pred_btb_hit_o,
    output logic [PC_W-1:0]  pred_target_o,
    output logic [1:0]       pred_ctr_o,
    output logic [GHR_W-1:0] pred_ghr_o,
    input  logic             upd_valid_i,
    input  logic [PC_W-1:0]  upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [PC_W-1:0]  upd_target_i,
    input  logic [1:0]       upd_ctr_i,
    input  logic [GHR_W-1:0] upd_ghr_i,
    input  logic             upd_mispredict_i
);

    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;

    logic [1:0]      r_pht     [PHT_N];
    logic            r_btb_v   [BTB_N];
    logic [TAG_W-1:0] r_btb_tag [BTB_N];
    logic [PC_W-1:0] r_btb_tgt [BTB_N];

    logic [PHT_IDX_W-1:0] w_lk_pidx;
    logic [PHT_IDX_W-1:0] w_up_pidx;
    logic [BTB_IDX_W-1:0] w_lk_bidx;
    logic [BTB_IDX_W-1:0] w_up_bidx;
    logic [TAG_W-1:0]     w_lk_tag;
    logic [TAG_W-1:0]     w_up_tag;
    logic [1:0]           w_lk_ctr;
    logic                 w_lk_hit;
    logic                 w_lk_taken;
    logic [1:0]           w_up_ctr;
    logic                 w_unused;

    assign w_lk_bidx = pc_i[BTB_IDX_W+1:2];
    assign w_up_bidx = upd_pc_i[BTB_IDX_W+1:2];
    assign w_lk_tag  = pc_i[TAG_W+BTB_IDX_W+1 -: TAG_W];
    assign w_up_tag  = upd_pc_i[TAG_W+BTB_IDX_W+1 -: TAG_W];

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] r_ghr;

    assign w_lk_pidx = pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(r_ghr);
    assign w_up_pidx = upd_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr_i);
    assign w_unused  = ^{pc_i, upd_pc_i};

    // A misprediction restore overrides the speculative shift of the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ghr      <= '0;
            pred_ghr_o <= '0;
        end else begin
            if (upd_valid_i && upd_mispredict_i)
                r_ghr <= GHR_W'({upd_ghr_i, upd_taken_i});
            else if (if_allowin_i && w_lk_hit)
                r_ghr <= GHR_W'({r_ghr, w_lk_taken});
            if (if_allowin_i)
                pred_ghr_o <= r_ghr;
        end
    end
`else
    assign w_lk_pidx  = pc_i[PHT_IDX_W+1:2];
    assign w_up_pidx  = upd_pc_i[PHT_IDX_W+1:2];
    assign pred_ghr_o = '0;
    assign w_unused   = ^{pc_i, upd_pc_i, upd_ghr_i, upd_mispredict_i};
`endif

    assign w_lk_ctr   = r_pht[w_lk_pidx];
    assign w_lk_hit   = r_btb_v[w_lk_bidx] && (r_btb_tag[w_lk_bidx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit & w_lk_ctr[1];

    always_comb begin
        w_up_ctr = upd_ctr_i;
        if (upd_taken_i) begin
            if (upd_ctr_i != 2'b11)
                w_up_ctr = upd_ctr_i + 2'b01;
        end else begin
            if (upd_ctr_i != 2'b00)
                w_up_ctr = upd_ctr_i - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PHT_N; i++)
                r_pht[i] <= 2'b01;
        end else if (upd_valid_i) begin
            r_pht[w_up_pidx] <= w_up_ctr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_N; i++) begin
                r_btb_v[i]   <= 1'b0;
                r_btb_tag[i] <= '0;
                r_btb_tgt[i] <= '0;
            end
        end else if (upd_valid_i && upd_taken_i) begin
            r_btb_v[w_up_bidx]   <= 1'b1;
            r_btb_tag[w_up_bidx] <= w_up_tag;
            r_btb_tgt[w_up_bidx] <= upd_target_i;
        end
    end

    // Reads see pre-update array contents: no write-to-read bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_valid_o   <= 1'b0;
            pred_taken_o   <= 1'b0;
            pred_btb_hit_o <= 1'b0;
            pred_target_o  <= '0;
            pred_ctr_o     <= '0;
        end else begin
            pred_valid_o <= if_allowin_i;
            if (if_allowin_i) begin
                pred_taken_o   <= w_lk_taken;
                pred_btb_hit_o <= w_lk_hit;
                pred_target_o  <= r_btb_tgt[w_lk_bidx];
                pred_ctr_o     <= w_lk_ctr;
            end
        end
    end

endmodule
